// File: rtl/nrisc_pkg.sv
// Shared nRISC datapath types and sizes, used by the register file,
// extensor1p3 and the decoder.
package nrisc_pkg;
  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;

  typedef logic [DATA_W-1:0]     dado_t;
  typedef logic [REG_ADDR_W-1:0] reg_end_t;
  typedef logic [NUM_REGS-1:0]   pend_t;

  // One-hot mask selecting a single register.
  function automatic pend_t decod_end(input reg_end_t e);
    return pend_t'(1) << e;
  endfunction
endpackage

// File: rtl/banco_registradores_if.sv
// Operand-read, write-back and reserve bus of the nRISC register file.
interface banco_registradores_if;
  import nrisc_pkg::*;

  reg_end_t ra_end;
  reg_end_t rb_end;
  dado_t    ra_dado;
  dado_t    rb_dado;
  logic     esc_en;
  reg_end_t esc_end;
  dado_t    esc_dado;
  logic     res_en;
  reg_end_t res_end;
  logic     stall;
  pend_t    pendentes;

  modport master (
    output ra_end, rb_end, esc_en, esc_end, esc_dado, res_en, res_end,
    input  ra_dado, rb_dado, stall, pendentes
  );

  modport slave (
    input  ra_end, rb_end, esc_en, esc_end, esc_dado, res_en, res_end,
    output ra_dado, rb_dado, stall, pendentes
  );
endinterface

// File: rtl/placar_pendencias.sv
// Pending-register scoreboard and operand stall.
// BANCO_BYPASS_EN: a register written this cycle no longer stalls its reader.
module placar_pendencias
  import nrisc_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     esc_en,
  input  reg_end_t esc_end,
  input  logic     res_en,
  input  reg_end_t res_end,
  input  reg_end_t ra_end,
  input  reg_end_t rb_end,
  output pend_t    pendentes,
  output logic     stall
);

  pend_t pend_q;
  pend_t limpa;
  pend_t marca;
  pend_t pend_vis;

  assign limpa = esc_en ? decod_end(esc_end) : '0;
  assign marca = res_en ? decod_end(res_end) : '0;

  // Set is applied after clear so a new reservation wins over the completing write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pend_q <= '0;
    else       pend_q <= (pend_q & ~limpa) | marca;
  end

`ifdef BANCO_BYPASS_EN
  assign pend_vis = pend_q & ~limpa;
`else
  assign pend_vis = pend_q;
`endif

  assign stall     = pend_vis[ra_end] | pend_vis[rb_end];
  assign pendentes = pend_q;

endmodule

// File: rtl/banco_registradores.sv
// nRISC register file: 8x8 array, two combinational read ports, one write-back.
// BANCO_BYPASS_EN: forwards same-cycle write-back data to the read ports.
module banco_registradores
  import nrisc_pkg::*;
(
  input logic                  clock,
  input logic                  reset,
  banco_registradores_if.slave bus
);

  dado_t regs [NUM_REGS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (bus.esc_en) begin
      regs[bus.esc_end] <= bus.esc_dado;
    end
  end

`ifdef BANCO_BYPASS_EN
  assign bus.ra_dado = (bus.esc_en && bus.esc_end == bus.ra_end) ? bus.esc_dado : regs[bus.ra_end];
  assign bus.rb_dado = (bus.esc_en && bus.esc_end == bus.rb_end) ? bus.esc_dado : regs[bus.rb_end];
`else
  assign bus.ra_dado = regs[bus.ra_end];
  assign bus.rb_dado = regs[bus.rb_end];
`endif

  placar_pendencias u_placar (
    .clock     (clock),
    .reset     (reset),
    .esc_en    (bus.esc_en),
    .esc_end   (bus.esc_end),
    .res_en    (bus.res_en),
    .res_end   (bus.res_end),
    .ra_end    (bus.ra_end),
    .rb_end    (bus.rb_end),
    .pendentes (bus.pendentes),
    .stall     (bus.stall)
  );

endmodule

// File: tb/tb_banco_registradores.sv
// Self-checking bench for banco_registradores against an array/bitmask reference model.
module tb_banco_registradores;
  import nrisc_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] m_reg [8];
  logic [7:0] m_pend;

  banco_registradores_if bus ();

  banco_registradores dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

`ifdef BANCO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  function automatic logic [7:0] exp_read(input logic [2:0] a);
    if (BYPASS && bus.esc_en && bus.esc_end == a) return bus.esc_dado;
    return m_reg[a];
  endfunction

  function automatic logic exp_stall();
    logic [7:0] p;
    p = m_pend;
    if (BYPASS && bus.esc_en) p[bus.esc_end] = 1'b0;
    return p[bus.ra_end] | p[bus.rb_end];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
    m_pend = 8'h00;
  endtask

  // Advance one clock: model absorbs the edge, bench returns at the negedge.
  task automatic tick();
    @(posedge clock);
    if (!reset) begin
      if (bus.esc_en) begin
        m_reg[bus.esc_end]  = bus.esc_dado;
        m_pend[bus.esc_end] = 1'b0;
      end
      if (bus.res_en) m_pend[bus.res_end] = 1'b1;
    end
    @(negedge clock);
    bus.esc_en = 1'b0;
    bus.res_en = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.ra_end = 3'd0; bus.rb_end = 3'd0;
    bus.esc_en = 1'b0; bus.esc_end = 3'd0; bus.esc_dado = 8'h00;
    bus.res_en = 1'b0; bus.res_end = 3'd0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    model_reset();
    @(negedge clock); #1;
    checks++;
    if (bus.pendentes !== 8'h00 || bus.stall !== 1'b0 || bus.ra_dado !== 8'h00) begin
      errors++;
      $display("FAIL reset_initial pend=%h stall=%b ra=%h required 00/0/00", bus.pendentes, bus.stall, bus.ra_dado);
    end
    reset = 1'b0;
    // Load state, then reset asynchronously between edges.
    bus.esc_en = 1'b1; bus.esc_end = 3'd3; bus.esc_dado = 8'hAA;
    bus.res_en = 1'b1; bus.res_end = 3'd5;
    tick();
    bus.ra_end = 3'd3; bus.rb_end = 3'd5;
    #1;
    checks++;
    if (bus.ra_dado !== 8'hAA || bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_preload ra=%h stall=%b required AA/1", bus.ra_dado, bus.stall);
    end
    #1 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (bus.ra_dado !== 8'h00 || bus.rb_dado !== 8'h00 || bus.pendentes !== 8'h00 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_async ra=%h rb=%h pend=%h stall=%b required 00/00/00/0",
               bus.ra_dado, bus.rb_dado, bus.pendentes, bus.stall);
    end
    @(negedge clock);
    reset = 1'b0;
    // First write after release must land on the very next edge.
    bus.esc_en = 1'b1; bus.esc_end = 3'd1; bus.esc_dado = 8'h3C;
    tick();
    bus.ra_end = 3'd1;
    #1;
    checks++;
    if (bus.ra_dado !== 8'h3C) begin
      errors++;
      $display("FAIL reset_first_write ra=%h required 3C", bus.ra_dado);
    end
  endtask

  task automatic test_write_read();
    do_reset();
    idle_inputs();
    bus.ra_end = 3'd5;
    bus.esc_en = 1'b1; bus.esc_end = 3'd5; bus.esc_dado = 8'h5C;
    #1;
    checks++;
    if (bus.ra_dado !== (BYPASS ? 8'h5C : 8'h00)) begin
      errors++;
      $display("FAIL write_same_cycle ra=%h required %h", bus.ra_dado, BYPASS ? 8'h5C : 8'h00);
    end
    tick();
    #1;
    checks++;
    if (bus.ra_dado !== 8'h5C) begin
      errors++;
      $display("FAIL write_next_cycle ra=%h required 5C", bus.ra_dado);
    end
  endtask

  task automatic test_reserve_stall();
    do_reset();
    idle_inputs();
    bus.res_en = 1'b1; bus.res_end = 3'd2; bus.rb_end = 3'd2;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL reserve_not_visible stall=%b required 0", bus.stall);
    end
    tick();
    #1;
    checks++;
    if (bus.stall !== 1'b1 || bus.pendentes !== 8'h04) begin
      errors++;
      $display("FAIL reserve_stall stall=%b pend=%h required 1/04", bus.stall, bus.pendentes);
    end
    bus.esc_en = 1'b1; bus.esc_end = 3'd2; bus.esc_dado = 8'h11;
    #1;
    checks++;
    if (bus.stall !== !BYPASS) begin
      errors++;
      $display("FAIL release_same_cycle stall=%b required %b", bus.stall, !BYPASS);
    end
    tick();
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.rb_dado !== 8'h11 || bus.pendentes !== 8'h00) begin
      errors++;
      $display("FAIL release_next_cycle stall=%b rb=%h pend=%h required 0/11/00",
               bus.stall, bus.rb_dado, bus.pendentes);
    end
  endtask

  task automatic test_same_addr();
    do_reset();
    idle_inputs();
    bus.esc_en = 1'b1; bus.esc_end = 3'd6; bus.esc_dado = 8'h7F;
    bus.res_en = 1'b1; bus.res_end = 3'd6;
    tick();
    bus.ra_end = 3'd6;
    #1;
    checks++;
    if (bus.ra_dado !== 8'h7F || bus.pendentes !== 8'h40 || bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL reserve_write_same ra=%h pend=%h stall=%b required 7F/40/1",
               bus.ra_dado, bus.pendentes, bus.stall);
    end
  endtask

  task automatic test_diff_addr();
    do_reset();
    idle_inputs();
    bus.esc_en = 1'b1; bus.esc_end = 3'd1; bus.esc_dado = 8'h99;
    tick();
    bus.esc_en = 1'b1; bus.esc_end = 3'd4; bus.esc_dado = 8'h22;
    bus.res_en = 1'b1; bus.res_end = 3'd1;
    tick();
    bus.ra_end = 3'd4; bus.rb_end = 3'd1;
    #1;
    checks++;
    if (bus.pendentes !== 8'h02 || bus.ra_dado !== 8'h22 || bus.rb_dado !== 8'h99) begin
      errors++;
      $display("FAIL reserve_write_diff pend=%h ra=%h rb=%h required 02/22/99",
               bus.pendentes, bus.ra_dado, bus.rb_dado);
    end
  endtask

  task automatic test_sweep();
    do_reset();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      bus.esc_en = 1'b1; bus.esc_end = 3'(i); bus.esc_dado = 8'(i * 8'h11);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      bus.ra_end = 3'(i); bus.rb_end = 3'(7 - i);
      #1;
      checks++;
      if (bus.ra_dado !== 8'(i * 8'h11) || bus.rb_dado !== 8'((7 - i) * 8'h11) || bus.stall !== 1'b0) begin
        errors++;
        $display("FAIL sweep_r%0d ra=%h rb=%h stall=%b required %h/%h/0", i, bus.ra_dado, bus.rb_dado,
                 bus.stall, 8'(i * 8'h11), 8'((7 - i) * 8'h11));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    idle_inputs();
    for (int n = 0; n < 300; n++) begin
      bus.ra_end   = 3'($urandom_range(0, 7));
      bus.rb_end   = 3'($urandom_range(0, 7));
      bus.esc_en   = ($urandom_range(0, 2) != 0);
      bus.esc_end  = 3'($urandom_range(0, 7));
      bus.esc_dado = 8'($urandom);
      bus.res_en   = ($urandom_range(0, 2) == 0);
      bus.res_end  = 3'($urandom_range(0, 7));
      #1;
      checks++;
      if (bus.ra_dado !== exp_read(bus.ra_end) || bus.rb_dado !== exp_read(bus.rb_end) ||
          bus.stall !== exp_stall() || bus.pendentes !== m_pend) begin
        errors++;
        $display("FAIL random_%0d ra=%h/%h rb=%h/%h stall=%b/%b pend=%h/%h (actual/required)", n,
                 bus.ra_dado, exp_read(bus.ra_end), bus.rb_dado, exp_read(bus.rb_end),
                 bus.stall, exp_stall(), bus.pendentes, m_pend);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_reserve_stall();
    test_same_addr();
    test_diff_addr();
    test_sweep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
